// File: rtl/y86_pkg.sv
// Shared Y86 encodings: icodes, status codes, register sentinel, run states
// and the pipeline control bundle.
package y86_pkg;

  localparam int unsigned ICODE_W = 4;
  localparam int unsigned STAT_W  = 3;
  localparam int unsigned REG_W   = 4;

  localparam logic [ICODE_W-1:0] I_HALT   = 4'h0;
  localparam logic [ICODE_W-1:0] I_NOP    = 4'h1;
  localparam logic [ICODE_W-1:0] I_RRMOVQ = 4'h2;
  localparam logic [ICODE_W-1:0] I_IRMOVQ = 4'h3;
  localparam logic [ICODE_W-1:0] I_RMMOVQ = 4'h4;
  localparam logic [ICODE_W-1:0] I_MRMOVQ = 4'h5;
  localparam logic [ICODE_W-1:0] I_OPQ    = 4'h6;
  localparam logic [ICODE_W-1:0] I_JXX    = 4'h7;
  localparam logic [ICODE_W-1:0] I_CALL   = 4'h8;
  localparam logic [ICODE_W-1:0] I_RET    = 4'h9;
  localparam logic [ICODE_W-1:0] I_PUSHQ  = 4'hA;
  localparam logic [ICODE_W-1:0] I_POPQ   = 4'hB;

  localparam logic [STAT_W-1:0] S_AOK = 3'd1;
  localparam logic [STAT_W-1:0] S_HLT = 3'd2;
  localparam logic [STAT_W-1:0] S_ADR = 3'd3;
  localparam logic [STAT_W-1:0] S_INS = 3'd4;

  localparam logic [REG_W-1:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    RS_FLUSH  = 2'd0,
    RS_RUN    = 2'd1,
    RS_DRAIN  = 2'd2,
    RS_HALTED = 2'd3
  } run_state_e;

  // Stall/bubble controls for the F/D/E/M/W pipeline registers
  typedef struct packed {
    logic f_stall;
    logic d_stall;
    logic d_bubble;
    logic e_bubble;
    logic m_bubble;
    logic w_stall;
  } pipe_ctrl_t;

  // True for any status that stops the machine
  function automatic logic is_exc(input logic [STAT_W-1:0] s);
    return (s == S_HLT) || (s == S_ADR) || (s == S_INS);
  endfunction

endpackage

// File: rtl/pipe_perf_counter.sv
// Single saturating event counter with enable; holds at all-ones.
module pipe_perf_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Increment when enabled unless already saturated
  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Counter register, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_control.sv
// Y86 five-stage hazard and run-state controller.
// Optional performance counters are built when PIPE_PERF_COUNTERS_EN is defined;
// otherwise the perf_* outputs are tied to zero.
module pipe_control
  import y86_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 3,
  parameter int unsigned COUNTER_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ICODE_W-1:0]   D_icode,
  input  logic [REG_W-1:0]     d_srcA,
  input  logic [REG_W-1:0]     d_srcB,
  input  logic [ICODE_W-1:0]   E_icode,
  input  logic [REG_W-1:0]     E_dstM,
  input  logic                 e_cnd,
  input  logic [ICODE_W-1:0]   M_icode,
  input  logic [STAT_W-1:0]    m_stat,
  input  logic [STAT_W-1:0]    W_stat,
  output logic                 F_stall,
  output logic                 D_stall,
  output logic                 D_bubble,
  output logic                 E_bubble,
  output logic                 M_bubble,
  output logic                 W_stall,
  output logic [1:0]           run_state,
  output logic [STAT_W-1:0]    exc_code,
  output logic [COUNTER_W-1:0] perf_cycles,
  output logic [COUNTER_W-1:0] perf_loaduse,
  output logic [COUNTER_W-1:0] perf_mispred,
  output logic [COUNTER_W-1:0] perf_ret
);

  localparam int unsigned FCNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

  run_state_e          state_q, state_d;
  logic [FCNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [STAT_W-1:0]   exc_code_q, exc_code_d;
  pipe_ctrl_t          ctrl;

  logic loaduse_c;
  logic mispred_c;
  logic retp_c;

  // Hazard detection on the current stage contents
  assign loaduse_c = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                     (E_dstM != RNONE) &&
                     ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign mispred_c = (E_icode == I_JXX) && !e_cnd;
  assign retp_c    = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);

  // State register: run state, flush counter and latched exception code
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RS_FLUSH;
      flush_cnt_q <= '0;
      exc_code_q  <= S_AOK;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      exc_code_q  <= exc_code_d;
    end
  end

  // Next-state logic; a writeback exception wins over a memory exception
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    exc_code_d  = exc_code_q;
    unique case (state_q)
      RS_FLUSH: begin
        if (flush_cnt_q == FCNT_W'(FLUSH_CYCLES - 1)) begin
          state_d     = RS_RUN;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + FCNT_W'(1);
        end
      end
      RS_RUN: begin
        if (is_exc(W_stat)) begin
          state_d    = RS_HALTED;
          exc_code_d = W_stat;
        end else if (is_exc(m_stat)) begin
          state_d = RS_DRAIN;
        end
      end
      RS_DRAIN: begin
        if (is_exc(W_stat)) begin
          state_d    = RS_HALTED;
          exc_code_d = W_stat;
        end
      end
      RS_HALTED: state_d = RS_HALTED;
      default:   state_d = RS_FLUSH;
    endcase
  end

  // Output decode; reset presents the flush pattern
  always_comb begin
    ctrl = '0;
    if (rst) begin
      ctrl.d_bubble = 1'b1;
      ctrl.e_bubble = 1'b1;
      ctrl.m_bubble = 1'b1;
    end else begin
      unique case (state_q)
        RS_RUN, RS_DRAIN: begin
          ctrl.f_stall  = loaduse_c || retp_c;
          ctrl.d_stall  = loaduse_c;
          ctrl.d_bubble = mispred_c || (retp_c && !loaduse_c);
          ctrl.e_bubble = mispred_c || loaduse_c;
          ctrl.m_bubble = is_exc(m_stat) || is_exc(W_stat);
          ctrl.w_stall  = is_exc(W_stat);
          if (state_q == RS_DRAIN) begin
            ctrl.m_bubble = 1'b1;
            ctrl.f_stall  = 1'b1;
          end
        end
        RS_HALTED: begin
          ctrl.f_stall  = 1'b1;
          ctrl.d_stall  = 1'b1;
          ctrl.e_bubble = 1'b1;
          ctrl.m_bubble = 1'b1;
          ctrl.w_stall  = 1'b1;
        end
        default: begin
          ctrl.d_bubble = 1'b1;
          ctrl.e_bubble = 1'b1;
          ctrl.m_bubble = 1'b1;
        end
      endcase
    end
  end

  assign F_stall   = ctrl.f_stall;
  assign D_stall   = ctrl.d_stall;
  assign D_bubble  = ctrl.d_bubble;
  assign E_bubble  = ctrl.e_bubble;
  assign M_bubble  = ctrl.m_bubble;
  assign W_stall   = ctrl.w_stall;
  assign run_state = state_q;
  assign exc_code  = exc_code_q;

`ifdef PIPE_PERF_COUNTERS_EN
  logic count_en_c;
  assign count_en_c = (state_q == RS_RUN) || (state_q == RS_DRAIN);

  pipe_perf_counter #(.W(COUNTER_W)) u_perf_cycles (
    .clk(clk), .rst(rst), .en_i(count_en_c), .count_o(perf_cycles));
  pipe_perf_counter #(.W(COUNTER_W)) u_perf_loaduse (
    .clk(clk), .rst(rst), .en_i(count_en_c && loaduse_c), .count_o(perf_loaduse));
  pipe_perf_counter #(.W(COUNTER_W)) u_perf_mispred (
    .clk(clk), .rst(rst), .en_i(count_en_c && mispred_c), .count_o(perf_mispred));
  pipe_perf_counter #(.W(COUNTER_W)) u_perf_ret (
    .clk(clk), .rst(rst), .en_i(count_en_c && retp_c && !loaduse_c), .count_o(perf_ret));
`else
  assign perf_cycles  = '0;
  assign perf_loaduse = '0;
  assign perf_mispred = '0;
  assign perf_ret     = '0;
`endif

endmodule

// File: doc/pipe_control.md
Name: pipe_control

Overview:
- Hazard and sequencing controller for the five-stage Y86 pipeline (fetch, decode, execute, memory, writeback).
- Each cycle, reads stage icodes, register IDs, condition result and status codes.
- Drives stall and bubble controls for the F/D/E/M/W pipeline registers.
- Owns a small run-state machine that covers:
  - the post-reset flush;
  - exception drain;
  - the terminal halted condition.

Parameters:
- FLUSH_CYCLES, 3, number of cycles after reset during which D/E/M registers are forced to bubble.
- COUNTER_W, 32, width of each performance counter (used only with the optional feature).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- D_icode  input  4  icode held in the decode register.
- d_srcA  input  4  decode-stage source A register ID; 4'hF = none.
- d_srcB  input  4  decode-stage source B register ID; 4'hF = none.
- E_icode  input  4  icode held in the execute register.
- E_dstM  input  4  execute-stage memory destination register ID.
- e_cnd  input  1  branch/cmov condition computed in execute.
- M_icode  input  4  icode held in the memory register.
- m_stat  input  3  status produced by the memory stage.
- W_stat  input  3  status held in the writeback register.
- F_stall  output  1  hold the fetch PC register.
- D_stall  output  1  hold the decode register.
- D_bubble  output  1  load nop into the decode register.
- E_bubble  output  1  load nop into the execute register.
- M_bubble  output  1  load nop into the memory register.
- W_stall  output  1  hold the writeback register.
- run_state  output  2  0 FLUSH, 1 RUN, 2 DRAIN, 3 HALTED.
- exc_code  output  3  W_stat latched on entry to HALTED; 1 (AOK) otherwise.
- perf_cycles, perf_loaduse, perf_mispred, perf_ret  output  COUNTER_W each  performance counters.

Behaviour:
Encodings:
- icode: HALT 0, NOP 1, RRMOVQ 2, IRMOVQ 3, RMMOVQ 4, MRMOVQ 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSHQ A, POPQ B.
- stat: AOK 1, HLT 2, ADR 3, INS 4.
- exc(s) is true when s is HLT, ADR or INS.

Hazard terms (combinational):
- loaduse = E_icode in {MRMOVQ, POPQ} && E_dstM != F && E_dstM in {d_srcA, d_srcB}.
- mispred = E_icode == JXX && !e_cnd.
- retp = RET in {D_icode, E_icode, M_icode}.

Outputs in RUN (combinational, same cycle):
- F_stall = loaduse || retp.
- D_stall = loaduse.
- D_bubble = mispred || (retp && !loaduse).
- E_bubble = mispred || loaduse.
- M_bubble = exc(m_stat) || exc(W_stat).
- W_stall = exc(W_stat).

Simultaneous events:
- loaduse and mispred cannot coexist, because E_icode differs.
- ret + loaduse: D_stall=1, E_bubble=1, D_bubble=0.
- ret + mispred: D_bubble=1, E_bubble=1, F_stall=1.
- D_stall and D_bubble are never both 1.

State machine (registered, updated on clk):
- rst=1: next state FLUSH, flush counter=0, exc_code=AOK. Reset mid-operation aborts any state, including HALTED.
- FLUSH:
  - Outputs: F_stall=0, D_bubble=1, E_bubble=1, M_bubble=1, D_stall=0, W_stall=0.
  - Counter increments each cycle; after FLUSH_CYCLES cycles, go to RUN.
  - Reset outputs equal FLUSH with count 0.
- RUN:
  - Equations above.
  - exc(m_stat) -> DRAIN.
  - exc(W_stat) without prior DRAIN -> HALTED directly.
- DRAIN:
  - Equations above, with M_bubble forced to 1 and F_stall forced to 1.
  - exc(W_stat) -> HALTED, latching exc_code=W_stat.
- HALTED:
  - F_stall=1, D_stall=1, E_bubble=1, M_bubble=1, W_stall=1, D_bubble=0.
  - Sticky until rst.
- run_state reflects the registered state.

Optional Feature:
- Macro: PIPE_PERF_COUNTERS_EN.
- Defined:
  - Four COUNTER_W saturating counters, cleared on rst, counting only in RUN/DRAIN.
  - perf_cycles counts every cycle.
  - perf_loaduse counts cycles with loaduse.
  - perf_mispred counts cycles with mispred.
  - perf_ret counts cycles with retp && !loaduse.
  - At all-ones, each counter holds.
- Undefined: counter logic is absent and the perf_* ports are tied to 0.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants;
  - stat constants AOK/HLT/ADR/INS;
  - RNONE=4'hF;
  - run-state encoding.
- One natural sub-module: pipe_perf_counter, a single saturating counter with enable, instantiated four times under the macro.
- Hazard equations stay in pipe_control.

Test Plan:
- Reset, FLUSH_CYCLES=3: assert rst 1 cycle -> run_state=0 and D/E/M_bubble=1 for 3 cycles; then run_state=1 with all controls 0 given NOP icodes and AOK stats.
- Load/use: E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0. The same with E_dstM=F -> all 0.
- Mispredict: E_icode=7, e_cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0. With e_cnd=1 -> all 0.
- Ret: D_icode=9 for one cycle, then E_icode=9, then M_icode=9 -> F_stall=1 and D_bubble=1 each of the 3 cycles. Then D_icode=9 with loaduse true -> D_bubble=0, D_stall=1.
- Exception: m_stat=3 -> M_bubble=1 and run_state=2 next cycle. W_stat=3 -> run_state=3, exc_code=3, all stall/bubble outputs at HALTED values. rst -> FLUSH.
- With PIPE_PERF_COUNTERS_EN and COUNTER_W=4:
  - 20 RUN cycles -> perf_cycles=15 (saturated);
  - 2 mispredict cycles -> perf_mispred=2;
  - rst -> all counters 0.
